// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle MIPS control FSM and ALU decoder
package mc_pkg;
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IDLE  = 2'b11;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps FSM aluop and instruction funct to the 3-bit ALU control
module alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] aluControl
);
  logic [2:0] fn_ctl;
  always_comb begin
    fn_ctl = funct == F_ADD ? ALU_ADD :
             funct == F_SUB ? ALU_SUB :
             funct == F_AND ? ALU_AND :
             funct == F_OR  ? ALU_OR  :
             funct == F_SLT ? ALU_SLT : ALU_AND;
    aluControl = aluop == ALUOP_ADD   ? ALU_ADD :
                 aluop == ALUOP_SUB   ? ALU_SUB :
                 aluop == ALUOP_FUNCT ? fn_ctl  : ALU_AND;
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM sequencing the multicycle MIPS datapath
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic               pcen,
  output logic [2:0]         aluControl,
  output logic [STATE_W-1:0] state,
  output logic               instr_done
);
  state_t st, nx;
  logic [1:0] aluop;
  logic pcwrite, branch, mw, iw, rw;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= FETCH;
    else st <= nx;
  always_comb begin
    nx = FETCH;
    iord = 1'b0;
    mw = 1'b0;
    iw = 1'b0;
    regdst = 1'b0;
    memtoreg = 1'b0;
    rw = 1'b0;
    alusrca = 1'b0;
    alusrcb = 2'b00;
    pcsrc = 2'b00;
    pcwrite = 1'b0;
    branch = 1'b0;
    aluop = ALUOP_IDLE;
    instr_done = 1'b0;
    case (st)
      FETCH: begin
        alusrcb = 2'b01;
        aluop = ALUOP_ADD;
        iw = 1'b1;
        pcwrite = 1'b1;
        nx = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        aluop = ALUOP_ADD;
        case (op)
          OP_LW, OP_SW: nx = MEMADR;
          OP_RTYPE: nx = EXECUTE;
          OP_BEQ: nx = BRANCH;
          OP_ADDI: nx = ADDIEXEC;
          OP_J: nx = JUMP;
          default: instr_done = 1'b1;
        endcase
      end
      MEMADR, ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop = ALUOP_ADD;
        nx = st == ADDIEXEC ? ADDIWB : op == OP_SW ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord = 1'b1;
        nx = MEMWB;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        rw = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        iord = 1'b1;
        mw = 1'b1;
        instr_done = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop = ALUOP_FUNCT;
        nx = ALUWB;
      end
      ALUWB: begin
        regdst = 1'b1;
        rw = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop = ALUOP_SUB;
        pcsrc = 2'b01;
        branch = 1'b1;
        instr_done = 1'b1;
      end
      ADDIWB: begin
        rw = 1'b1;
        instr_done = 1'b1;
      end
      JUMP: begin
        pcsrc = 2'b10;
        pcwrite = 1'b1;
        instr_done = 1'b1;
      end
      default: nx = FETCH;
    endcase
  end
  alu_decoder u_dec (.aluop(aluop), .funct(funct), .aluControl(aluControl));
  // write enables drop as soon as rst_n falls, before the state register reacts
  assign memwrite = mw & rst_n;
  assign irwrite = iw & rst_n;
  assign regwrite = rw & rst_n;
  assign pcen = (pcwrite | (branch & zero)) & rst_n;
  assign state = STATE_W'(st);
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: random instruction stream checked against a per-instruction sequence model
module tb_multicycle_controller;
  typedef int iq_t[$];
  logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0;
  logic [5:0] op = 6'd0, funct = 6'd0;
  logic iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, instr_done;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluControl;
  logic [3:0] state;
  int checks = 0, failures = 0;
  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .pcen(pcen), .aluControl(aluControl), .state(state), .instr_done(instr_done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic iq_t seq_of(input logic [5:0] o);
    case (o)
      6'b100011: return '{0, 1, 2, 3, 4};
      6'b101011: return '{0, 1, 2, 5};
      6'b000000: return '{0, 1, 6, 7};
      6'b001000: return '{0, 1, 9, 10};
      6'b000100: return '{0, 1, 8};
      6'b000010: return '{0, 1, 11};
      default:   return '{0, 1};
    endcase
  endfunction
  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'h20: return 3'b010;
      6'h22: return 3'b110;
      6'h24: return 3'b000;
      6'h25: return 3'b001;
      6'h2a: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction
  // {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,aluControl}
  function automatic logic [13:0] ctrl_ref(input int s, input logic [5:0] f);
    logic io = 0, mw = 0, iw = 0, rd = 0, mr = 0, rw = 0, sa = 0;
    logic [1:0] sb = 0, ps = 0;
    logic [2:0] al = 0;
    case (s)
      0: begin sb = 2'b01; al = 3'b010; iw = 1; end
      1: begin sb = 2'b11; al = 3'b010; end
      2, 9: begin sa = 1; sb = 2'b10; al = 3'b010; end
      3: io = 1;
      4: begin mr = 1; rw = 1; end
      5: begin io = 1; mw = 1; end
      6: begin sa = 1; al = alu_of(f); end
      7: begin rd = 1; rw = 1; end
      8: begin sa = 1; al = 3'b110; ps = 2'b01; end
      10: rw = 1;
      11: ps = 2'b10;
      default: ;
    endcase
    return {io, mw, iw, rd, mr, rw, sa, sb, ps, al};
  endfunction
  task automatic check_cycle(input int s, input logic [5:0] f, input bit last);
    check($sformatf("state@%0d", s), 32'(state), 32'(s));
    check($sformatf("ctrl@%0d", s),
          32'({iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, pcsrc, aluControl}),
          32'(ctrl_ref(s, f)));
    check($sformatf("pcen@%0d", s), 32'(pcen), 32'(s == 0 || s == 11 || (s == 8 && zero)));
    check($sformatf("done@%0d", s), 32'(instr_done), 32'(last));
  endtask
  // zm: 0/1 force zero, 2 random each cycle
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zm);
    iq_t q = seq_of(o);
    op = o;
    funct = f;
    foreach (q[i]) begin
      zero = zm == 2 ? 1'($urandom) : 1'(zm);
      #2;
      check_cycle(q[i], f, i == q.size() - 1);
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    logic [5:0] legal_ops[6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    logic [5:0] legal_fn[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_state", 32'(state), 0);
      check("rst_we", 32'({memwrite, regwrite, irwrite, pcen}), 0);
    end
    rst_n = 1'b1;
    #1;
    check("rel_state", 32'(state), 0);
    check("rel_ir_pc", 32'({irwrite, pcen}), 32'b11);
    run_instr(6'b100011, 6'h00, 2);
    run_instr(6'b000000, 6'h2a, 2);
    run_instr(6'b000000, 6'h22, 2);
    run_instr(6'b000000, 6'h25, 2);
    run_instr(6'b000000, 6'h3f, 2);
    run_instr(6'b000100, 6'h00, 1);
    run_instr(6'b000100, 6'h00, 0);
    run_instr(6'b111111, 6'h00, 2);
    run_instr(6'b000010, 6'h00, 2);
    run_instr(6'b001000, 6'h00, 2);
    run_instr(6'b101011, 6'h00, 2);
    op = 6'b101011;
    for (int i = 0; i < 3; i++) begin
      #2;
      check_cycle(i == 0 ? 0 : i == 1 ? 1 : 2, 6'h00, 1'b0);
      @(posedge clk);
      #1;
    end
    check("memwr_state", 32'(state), 5);
    check("memwr_we", 32'(memwrite), 1);
    rst_n = 1'b0;
    #1;
    check("abort_we", 32'({memwrite, regwrite, irwrite, pcen}), 0);
    check("abort_state", 32'(state), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("abort_rel", 32'(state), 0);
    for (int n = 0; n < 300; n++) begin
      logic [5:0] o, f;
      o = legal_ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 6) == 0)
        do o = 6'($urandom); while (o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010});
      f = $urandom_range(0, 1) ? legal_fn[$urandom_range(0, 4)] : 6'($urandom);
      run_instr(o, f, 2);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control FSM for the multicycle MIPS datapath. It sits directly upstream of the ALU and drives its 3-bit aluControl and operand-select muxes. It consumes the ALU zero flag for beq and sequences fetch/decode/execute/memory/writeback over 3-5 cycles per instruction. Supported instructions: R-type (add, sub, and, or, slt), lw, sw, beq, addi, j.

Parameters:
STATE_W, 4, width of the state register.

Ports:
clk  in  1  system clock; all state changes occur on its rising edge
rst_n  in  1  asynchronous active-low reset
op  in  6  instruction opcode, instr[31:26], taken from the instruction register
funct  in  6  function field, instr[5:0]
zero  in  1  ALU zero flag
iord  out  1  memory address mux select: 0 = PC, 1 = ALUOut
memwrite  out  1  data memory write enable
irwrite  out  1  instruction register load enable
regdst  out  1  register write address select: 0 = rt, 1 = rd
memtoreg  out  1  register write data select: 0 = ALUOut, 1 = MDR
regwrite  out  1  register file write enable
alusrca  out  1  ALU A select: 0 = PC, 1 = register A
alusrcb  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
pcsrc  out  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target
pcen  out  1  PC load enable
aluControl  out  3  ALU op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
state  out  4  current state, exported for debug and the bench
instr_done  out  1  one-cycle pulse in the final state of each instruction

Behaviour:
- Moore FSM. All outputs except pcen are decoded combinationally from state; aluControl also depends on funct.
- pcen = pcwrite | (branch & zero), where pcwrite and branch are internal state-decoded signals.
- Reset: while rst_n = 0, state is forced to FETCH (0). memwrite, irwrite, regwrite and pcen are forced to 0, qualified combinationally with rst_n. Other outputs show FETCH decode values.
- Reset asserted mid-instruction aborts it immediately. No partial write completes after rst_n falls.
- State encodings:
  - 0 FETCH
  - 1 DECODE
  - 2 MEMADR
  - 3 MEMRD
  - 4 MEMWB
  - 5 MEMWR
  - 6 EXECUTE
  - 7 ALUWB
  - 8 BRANCH
  - 9 ADDIEXEC
  - 10 ADDIWB
  - 11 JUMP
- State outputs (signals not listed are 0):
  - FETCH: iord=0, alusrca=0, alusrcb=01, ADD, pcsrc=00, irwrite=1, pcwrite=1.
  - DECODE: alusrca=0, alusrcb=11, ADD (branch target into ALUOut).
  - MEMADR and ADDIEXEC: alusrca=1, alusrcb=10, ADD.
  - MEMRD: iord=1.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - EXECUTE: alusrca=1, alusrcb=00, aluControl from funct.
  - ALUWB: regdst=1, memtoreg=0, regwrite=1.
  - BRANCH: alusrca=1, alusrcb=00, SUB, pcsrc=01, branch=1.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1.
  - JUMP: pcsrc=10, pcwrite=1.
- Transitions:
  - FETCH -> DECODE.
  - DECODE dispatches on op: lw/sw -> MEMADR; R-type (000000) -> EXECUTE; beq -> BRANCH; addi -> ADDIEXEC; j -> JUMP; any other op -> FETCH (treated as NOP, no writes).
  - MEMADR -> MEMRD for lw, MEMWR for sw.
  - MEMRD -> MEMWB; EXECUTE -> ALUWB; ADDIEXEC -> ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP -> FETCH.
- Cycles per instruction, FETCH through final state: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- instr_done = 1 in MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP, and in DECODE for an illegal op.
- funct mapping in EXECUTE: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111. Any other funct -> 000, with regwrite still asserted in ALUWB.
- Unused state encodings 12-15 go to FETCH on the next edge with all enables 0.

Decomposition:
- Package mc_pkg holds:
  - state encodings;
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - funct constants;
  - aluControl codes: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT;
  - 2-bit aluop codes: 00 add, 01 sub, 10 funct.
- Sub-module alu_decoder (combinational; inputs aluop and funct, output aluControl). The FSM supplies aluop.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles, then release -> state = 0 during and after release. memwrite, regwrite, irwrite and pcen are 0 while rst_n = 0, and irwrite = pcen = 1 in the first cycle after release.
- lw (op = 100011) -> state sequence 0, 1, 2, 3, 4, 0. MEMADR shows alusrcb = 10, aluControl = 010. MEMWB shows regwrite = 1, memtoreg = 1. instr_done pulses once.
- R-type with funct = 101010 -> states 0, 1, 6, 7, 0. EXECUTE shows aluControl = 111. ALUWB shows regdst = 1, regwrite = 1. Repeat for funct 100010 -> 110 and 100101 -> 001.
- beq (op = 000100) -> BRANCH shows aluControl = 110, pcsrc = 01. With zero = 1, pcen = 1; with zero = 0, pcen = 0. Back to FETCH after 3 cycles either way.
- Illegal op = 111111 -> states 0, 1, 0, with no write enable asserted at any point. Then j (000010) -> states 0, 1, 11 with pcsrc = 10, pcen = 1.
- Reset mid-operation: drop rst_n while in state 5 (MEMWR) -> memwrite falls in the same cycle, with no clock edge required. State reads 0 after release.
